// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
//
// alu: combinational N-bit ALU.
//   a, b      operands
//   opcode    0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 sar, 8 not a, 9 pass b
//   y         result (0 for opcodes 10..15)
//   flags     {z, c, n, v}; c is carry for add, borrow for sub, shifted-out bit for shifts
//
// alu_arbiter: two valid/ready request channels feed one ALU; each requester gets
// its result back on its own valid/ready response channel.
//   clk, rst                  clock, asynchronous active-high reset
//   reqX_valid/ready          request handshake (ready is combinational on valid)
//   reqX_a, reqX_b, reqX_opcode  request payload
//   rspX_valid/ready          response handshake
//   rspX_y, rspX_flags, rspX_err  result, {z,c,n,v}, illegal-opcode marker

module alu #(
    parameter int PARAM_WIDTH = 8
) (
    input  logic [PARAM_WIDTH-1:0] a,
    input  logic [PARAM_WIDTH-1:0] b,
    input  logic [3:0]             opcode,
    output logic [PARAM_WIDTH-1:0] y,
    output logic [3:0]             flags
);
    localparam int W = PARAM_WIDTH;

    logic c;
    logic v;

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (opcode)
            4'd0: begin
                {c, y} = {1'b0, a} + {1'b0, b};
                v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'd1: begin
                // Top bit of the widened difference is the borrow.
                {c, y} = {1'b0, a} - {1'b0, b};
                v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: {c, y} = {a, 1'b0};
            4'd6: {y, c} = {1'b0, a};
            4'd7: {y, c} = {a[W-1], a};
            4'd8: y = ~a;
            4'd9: y = b;
            default: y = '0;
        endcase
    end

    assign flags = {(y == '0), c, y[W-1], v};
endmodule

module alu_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_opcode,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_opcode,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [N-1:0] rsp0_y,
    output logic [3:0]   rsp0_flags,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp1_y,
    output logic [3:0]   rsp1_flags,
    output logic         rsp1_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    logic         last_grant;
    logic         gnt_id;
    logic         grant;
    logic [N-1:0] lat_a;
    logic [N-1:0] lat_b;
    logic [3:0]   lat_op;
    logic [N-1:0] alu_y;
    logic [3:0]   alu_flags;
    logic         op_legal;

    alu #(.PARAM_WIDTH(N)) u_alu (
        .a      (lat_a),
        .b      (lat_b),
        .opcode (lat_op),
        .y      (alu_y),
        .flags  (alu_flags)
    );

    // With both requesting, the one not served last wins; otherwise whoever asks.
    assign grant    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign op_legal = (lat_op < 4'd10);

    assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_y     <= '0;
            rsp0_flags <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_y     <= '0;
            rsp1_flags <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        lat_a      <= grant ? req1_a      : req0_a;
                        lat_b      <= grant ? req1_b      : req0_b;
                        lat_op     <= grant ? req1_opcode : req0_opcode;
                        gnt_id     <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal opcodes return zero result and flags, ALU output unused.
                    if (!gnt_id) begin
                        rsp0_valid <= 1'b1;
                        rsp0_y     <= op_legal ? alu_y : '0;
                        rsp0_flags <= op_legal ? alu_flags : 4'b0000;
                        rsp0_err   <= !op_legal;
                    end else begin
                        rsp1_valid <= 1'b1;
                        rsp1_y     <= op_legal ? alu_y : '0;
                        rsp1_flags <= op_legal ? alu_flags : 4'b0000;
                        rsp1_err   <= !op_legal;
                    end
                    state <= RESP;
                end
                RESP: begin
                    // Payload is cleared on consumption so an idle channel always reads zero.
                    if (!gnt_id && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp0_y     <= '0;
                        rsp0_flags <= '0;
                        rsp0_err   <= 1'b0;
                        state      <= IDLE;
                    end else if (gnt_id && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        rsp1_y     <= '0;
                        rsp1_flags <= '0;
                        rsp1_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_opcode, req1_opcode;
    logic       rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
    logic [7:0] rsp0_y, rsp1_y;
    logic [3:0] rsp0_flags, rsp1_flags;

    alu_arbiter #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opcode(req1_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
        .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
        .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ch;
        logic [7:0] y;
        logic [3:0] f;
        logic       err;
    } exp_t;

    exp_t scb[$];
    int vectors = 0;
    int miscompares = 0;
    int pop_cyc[2];
    int acc_cyc[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Independent reference for the ALU, written with integer arithmetic.
    function automatic exp_t model(input logic ch, input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] op);
        exp_t e;
        int ua, ub, sa, sbv, r;
        logic c, v;
        logic [7:0] y;
        ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
        c = 1'b0; v = 1'b0; y = 8'h00;
        case (op)
            4'd0: begin r = ua + ub; y = r[7:0]; c = (r > 255);
                        v = ((sa + sbv) > 127) || ((sa + sbv) < -128); end
            4'd1: begin r = ua - ub; y = r[7:0]; c = (ua < ub);
                        v = ((sa - sbv) > 127) || ((sa - sbv) < -128); end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: begin r = (ua * 2) % 256; y = r[7:0]; c = (ua >= 128); end
            4'd6: begin r = ua / 2; y = r[7:0]; c = (ua % 2) == 1; end
            4'd7: begin r = sa >>> 1; y = r[7:0]; c = (ua % 2) == 1; end
            4'd8: begin r = 255 - ua; y = r[7:0]; end
            4'd9: y = b;
            default: ;
        endcase
        e.ch = ch;
        if (op >= 4'd10) begin
            e.y = 8'h00; e.f = 4'b0000; e.err = 1'b1;
        end else begin
            e.y = y; e.f = {(y == 8'h00), c, y[7], v}; e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(input logic ch, input logic [7:0] y, input logic [3:0] f, input logic err);
        exp_t e;
        e.ch = ch; e.y = y; e.f = f; e.err = err;
        scb.push_back(e);
    endtask

    // Monitor: every response handshake pops the scoreboard in order.
    initial begin : monitor
        exp_t e;
        logic v, r, ov;
        logic [7:0] y, oy;
        logic [3:0] f, of;
        logic er, oer;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp0_valid && rsp1_valid) begin
                    vectors++; miscompares++;
                    $display("FAIL both_rsp_valid actual=11 required=at most one");
                end
                for (int ch = 0; ch < 2; ch++) begin
                    v  = ch ? rsp1_valid : rsp0_valid;   r  = ch ? rsp1_ready : rsp0_ready;
                    y  = ch ? rsp1_y     : rsp0_y;       f  = ch ? rsp1_flags : rsp0_flags;
                    er = ch ? rsp1_err   : rsp0_err;
                    ov = ch ? rsp0_valid : rsp1_valid;   oy = ch ? rsp0_y     : rsp1_y;
                    of = ch ? rsp0_flags : rsp1_flags;   oer = ch ? rsp0_err  : rsp1_err;
                    if (v && r) begin
                        if (scb.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL unexpected_rsp ch=%0d actual=response required=none", ch);
                        end else begin
                            e = scb.pop_front();
                            check("rsp_channel", ch, e.ch);
                            check("rsp_y", y, e.y);
                            check("rsp_flags", f, e.f);
                            check("rsp_err", er, e.err);
                            check("other_rsp_idle", {ov, oy, of, oer}, 0);
                            pop_cyc[ch] = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic ch, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bit ok;
        ok = 0;
        if (ch) begin req1_a = a; req1_b = b; req1_opcode = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_opcode = op; req0_valid = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ch ? req1_ready : req0_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout ch=%0d actual=no ready required=ready", ch);
        end else begin
            acc_cyc[ch] = cyc;
        end
        @(posedge clk); #1;
        if (ch) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (scb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", scb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        scb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [7:0] sa0[20], sb0[20], sa1[20], sb1[20];
    logic [3:0] so0[20], so1[20];
    bit found;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 0; req0_b = 0; req0_opcode = 0;
        req1_a = 0; req1_b = 0; req1_opcode = 0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #12;
        check("reset_outputs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_y, rsp1_y,
                                rsp0_flags, rsp1_flags, rsp0_err, rsp1_err}, 0);
        req0_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single request: 6 + 0.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        push_exp(0, 8'd6, 4'b0000, 0);
        req0_a = 8'd6; req0_b = 8'd0; req0_opcode = 4'd0; req0_valid = 1'b1;
        #1;
        check("single_req0_ready", req0_ready, 1);
        check("single_req1_ready", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("single_rsp_not_yet", rsp0_valid, 0);
        @(posedge clk); #1;
        check("single_rsp0_valid_t2", rsp0_valid, 1);
        check("single_rsp1_quiet", rsp1_valid, 0);
        drain();

        // Simultaneous requests after reset: 0 first, then 1.
        do_reset();
        push_exp(0, 8'd200, 4'b0010, 0);   // 100 shl 1
        push_exp(1, 8'd11,  4'b0100, 0);   // 23 shr 1, carry out 1
        fork
            issue(0, 8'd100, 8'd50, 4'd5);
            issue(1, 8'd23, 8'd31, 4'd6);
        join
        drain();
        check("dual_rsp_spacing", pop_cyc[1] - pop_cyc[0], 3);

        // Backpressure on requester 0 while requester 1 waits.
        rsp0_ready = 1'b0;
        push_exp(0, 8'h05, 4'b0000, 0);    // 0x55 & 0x0f
        push_exp(1, 8'h7f, 4'b0001, 0);    // 0x80 - 1, signed overflow
        issue(0, 8'h55, 8'h0f, 4'd2);
        fork
            issue(1, 8'h80, 8'h01, 4'd1);
            begin
                found = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (rsp0_valid) begin found = 1; break; end
                end
                check("bp_rsp0_seen", found, 1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_hold", {rsp0_valid, rsp0_y, rsp0_flags, rsp0_err}, {1'b1, 8'h05, 4'b0000, 1'b0});
                    check("bp_ready_low", {req0_ready, req1_ready}, 0);
                end
                @(posedge clk); #1;
                rsp0_ready = 1'b1;
            end
        join
        drain();
        check("bp_accept_after_consume", acc_cyc[1], pop_cyc[0] + 1);

        // Illegal opcode on requester 1.
        push_exp(1, 8'h00, 4'b0000, 1);
        issue(1, 8'd46, 8'd0, 4'd12);
        drain();

        // Reset mid-EXEC.
        rsp0_ready = 1'b0;
        req0_a = 8'd1; req0_b = 8'd2; req0_opcode = 4'd0; req0_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1; req0_valid = 1'b0;
        #1;
        check("rst_exec_valid", {rsp0_valid, rsp1_valid}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_exec_discarded", {rsp0_valid, rsp1_valid}, 0);

        // Reset mid-RESP.
        issue(0, 8'd9, 8'd3, 4'd3);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin found = 1; break; end
        end
        check("rst_resp_rsp_seen", found, 1);
        #2; rst = 1'b1;
        #1;
        check("rst_resp_cleared", {rsp0_valid, rsp1_valid, rsp0_y, rsp0_flags}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Fairness soak: first dual request after reset must go to requester 0.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        sa0[0] = 8'hfc; sb0[0] = 8'd7; so0[0] = 4'd0;   // -4 + 7
        sa1[0] = 8'hf3; sb1[0] = 8'd0; so1[0] = 4'd1;   // -13 - 0
        push_exp(0, 8'h03, 4'b0100, 0);
        push_exp(1, 8'hf3, 4'b0010, 0);
        for (int k = 1; k < 20; k++) begin
            sa0[k] = 8'($urandom); sb0[k] = 8'($urandom); so0[k] = 4'($urandom_range(0, 15));
            sa1[k] = 8'($urandom); sb1[k] = 8'($urandom); so1[k] = 4'($urandom_range(0, 15));
            scb.push_back(model(0, sa0[k], sb0[k], so0[k]));
            scb.push_back(model(1, sa1[k], sb1[k], so1[k]));
        end
        fork
            begin for (int k = 0; k < 20; k++) issue(0, sa0[k], sb0[k], so0[k]); end
            begin for (int j = 0; j < 20; j++) issue(1, sa1[j], sb1[j], so1[j]); end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters; the ALU is instantiated inside this block with PARAM_WIDTH = N.
- Each requester presents an operand pair and an opcode over a valid/ready request channel.
- The block arbitrates round-robin, latches the winning operands and runs the ALU. It returns result and flags on that requester's own valid/ready response channel.
- It sits between the CPU issue logic and the ALU.

Parameters:
- N, 8, data width of operands and result; passed to ALU PARAM_WIDTH.

Ports:
- clk input 1: single clock, rising edge.
- rst input 1: asynchronous, active-high reset.
- req0_valid input 1: requester 0 has an operation.
- req0_ready output 1: requester 0 request accepted this cycle.
- req0_a, req0_b input N: requester 0 operands.
- req0_opcode input 4: requester 0 ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_opcode: same as requester 0, for requester 1.
- rsp0_valid output 1: response for requester 0 available.
- rsp0_ready input 1: requester 0 consumes the response.
- rsp0_y output N: result.
- rsp0_flags output 4: {z,c,n,v} from the ALU.
- rsp0_err output 1: illegal opcode.
- rsp1_valid, rsp1_ready, rsp1_y, rsp1_flags, rsp1_err: same as requester 0, for requester 1.

Behaviour:
- Reset (async, rst=1): state=IDLE; last_grant=1, so requester 0 wins first; all req*_ready=0, rsp*_valid=0, rsp*_y=0, rsp*_flags=0, rsp*_err=0; latched operands cleared. Reset mid-operation discards any in-flight operation and pending response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational on req*_valid.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester other than last_grant.
  - req_ready of the granted requester is high in the same cycle (ready depends on valid; nothing else).
  - On the clock edge: latch a, b, opcode and grant id; last_grant <= grant; go to EXEC.
  - No valid: stay IDLE, both ready=0.
- EXEC:
  - ALU driven from the latched a, b, opcode.
  - Opcode 0..9: register ALU y and {z,c,n,v} into the granted requester's rsp registers; err=0.
  - Opcode 10..15: y=0, flags=0, err=1; ALU output ignored.
  - Set rsp_valid of the granted requester; go to RESP.
- RESP:
  - rsp_valid held high, with y/flags/err stable, until rsp_ready=1 on a clock edge.
  - On that edge: rsp_valid<=0; go to IDLE.
  - Both req*_ready=0 throughout RESP and EXEC.
  - The other requester's rsp outputs stay 0/invalid.
- Latency:
  - Request accepted at edge T; rsp_valid high from T+2 (after the EXEC edge at T+1).
  - With rsp_ready already high, the response is consumed at edge T+2 and the next request is accepted at edge T+3.
  - Minimum issue interval is 3 cycles.
- Requester rules: req_valid and its payload must stay stable until ready; the block samples only on the accept cycle. Changes to a non-granted requester's payload are ignored.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1…; neither requester waits more than one operation.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Flags are passed through unmodified from the ALU; the block adds no flag logic.

Test Plan:
- Reset then single request: req0 a=6, b=0, opcode=0 with valid=1 → req0_ready=1 in that cycle; rsp0_valid=1 two edges later. rsp0_y and rsp0_flags must equal a standalone ALU instance's y and {z,c,n,v} for those inputs; rsp0_err=0; rsp1_valid stays 0.
- Simultaneous requests after reset: req0 (100,50,op 5) and req1 (23,31,op 6) held valid, rsp ready tied 1 → grant order 0 then 1. Each response matches the standalone ALU, on the correct channel. rsp1_valid first rises 3 cycles after rsp0_valid.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid → rsp0_valid/y/flags stable; both req*_ready=0 while req1_valid=1. Release → req1 accepted on the cycle after consumption.
- Illegal opcode: req1 opcode=12, a=46, b=0 → rsp1_err=1, rsp1_y=0, rsp1_flags=0000.
- Async reset mid-EXEC and mid-RESP: assert rst between edges → all rsp*_valid=0 immediately. After release, the first dual request is granted to requester 0.
- Fairness soak: 20 back-to-back dual requests with random operands (including a=-4, b=7; a=-13, b=0) → strictly alternating grants; every response matches the standalone ALU model.
